// File: rtl/affine_pkg.sv
// Shared definitions for the affine transform engine: default sizing, FSM
// state encoding and the flat coefficient-address helper.
package affine_pkg;

  localparam int N_DEF = 8;
  localparam int F_DEF = 6;
  localparam int D_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } tAffState;

  // Row r occupies D+1 consecutive slots: D matrix coefficients, then c[r].
  function automatic int coef_index(input int r, input int j, input int d);
    return r * (d + 1) + j;
  endfunction

endpackage

// File: rtl/affine_sat.sv
// Narrows a row sum to OW bits. With AFFINE_SAT_EN defined the value clamps to
// the signed OW-bit range and flags the clamp; otherwise it wraps, flag held 0.
module affine_sat #(
  parameter int IW = 17,
  parameter int OW = 8
) (
  input  logic signed [IW-1:0] sum_i,
  output logic        [OW-1:0] res_o,
  output logic                 sat_o
);

`ifdef AFFINE_SAT_EN
  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    res_o = sum_i[OW-1:0];
    sat_o = 1'b0;
    if (sum_i > MAXV) begin
      res_o = MAXV[OW-1:0];
      sat_o = 1'b1;
    end else if (sum_i < MINV) begin
      res_o = MINV[OW-1:0];
      sat_o = 1'b1;
    end
  end
`else
  logic unused_hi;

  assign res_o     = sum_i[OW-1:0];
  assign sat_o     = 1'b0;
  assign unused_hi = ^sum_i[IW-1:OW];
`endif

endmodule

// File: rtl/affine_mac_engine.sv
// y = M*x + c over D channels with one time-shared multiplier and valid/ready
// handshakes; optional output clamping is selected by AFFINE_SAT_EN.
module affine_mac_engine
  import affine_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int F  = F_DEF,
  parameter int D  = D_DEF,
  parameter int CA = $clog2(D*(D+1))
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            coef_we,
  input  logic [CA-1:0]   coef_addr,
  input  logic [N-1:0]    coef_wdata,
  output logic            coef_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [D*N-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [D*N-1:0]  out_data,
  output logic [D-1:0]    out_sat
);

  localparam int NCOEF = D * (D + 1);
  localparam int ACC_W = 2 * N + $clog2(D) + 1;
  localparam int RW    = (D > 1) ? $clog2(D) : 1;
  localparam logic [RW-1:0] LAST     = RW'(D - 1);
  localparam logic [CA:0]   NCOEF_W  = (CA+1)'(NCOEF);
  localparam logic [N-1:0]  COEF_ONE = N'(2 ** F);

  tAffState                 state_q, state_d;
  logic [RW-1:0]            r_q, r_d, j_q, j_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [N-1:0]             x_q    [D];
  logic [N-1:0]             x_d    [D];
  logic [N-1:0]             coef_q [NCOEF];
  logic [N-1:0]             coef_d [NCOEF];
  logic [N-1:0]             res_q  [D];
  logic [N-1:0]             res_d  [D];
  logic [D-1:0]             sat_q, sat_d;
  logic                     load_x;

  logic [CA-1:0]            m_idx, c_idx;
  logic signed [N-1:0]      m_cur, x_cur, c_cur;
  logic signed [2*N-1:0]    prod;
  logic signed [ACC_W-1:0]  mac_sum, row_shift, row_sum;
  logic [N-1:0]             row_res;
  logic                     row_sat;

  assign m_idx = CA'(coef_index(int'(r_q), int'(j_q), D));
  assign c_idx = CA'(coef_index(int'(r_q), D, D));
  assign m_cur = $signed(coef_q[m_idx]);
  assign x_cur = $signed(x_q[j_q]);
  assign c_cur = $signed(coef_q[c_idx]);

  assign prod      = m_cur * x_cur;
  assign mac_sum   = acc_q + $signed({{(ACC_W-2*N){prod[2*N-1]}}, prod});
  // Kept as its own signal so the shift stays arithmetic (floor toward -inf).
  assign row_shift = mac_sum >>> F;
  assign row_sum   = row_shift + $signed({{(ACC_W-N){c_cur[N-1]}}, c_cur});

  affine_sat #(
    .IW (ACC_W),
    .OW (N)
  ) u_sat (
    .sum_i (row_sum),
    .res_o (row_res),
    .sat_o (row_sat)
  );

  // IDLE | ready for x and coefficient writes
  // MAC  | one product per cycle, row written out on its last column
  // DONE | result presented; handoff may chain straight into MAC
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    j_d        = j_q;
    acc_d      = acc_q;
    x_d        = x_q;
    coef_d     = coef_q;
    res_d      = res_q;
    sat_d      = sat_q;
    load_x     = 1'b0;
    coef_ready = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        coef_ready = 1'b1;
        in_ready   = 1'b1;
        load_x     = in_valid;
      end
      MAC: begin
        if (j_q == LAST) begin
          res_d[r_q] = row_res;
          sat_d[r_q] = row_sat;
          acc_d      = '0;
          j_d        = '0;
          if (r_q == LAST) begin
            r_d     = '0;
            state_d = DONE;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          acc_d = mac_sum;
          j_d   = j_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = IDLE;
          load_x  = in_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_x) begin
      for (int i = 0; i < D; i++) x_d[i] = in_data[i*N +: N];
      r_d     = '0;
      j_d     = '0;
      acc_d   = '0;
      state_d = MAC;
    end

    if (coef_we && coef_ready && ({1'b0, coef_addr} < NCOEF_W))
      coef_d[coef_addr] = coef_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      sat_q   <= '0;
      for (int i = 0; i < D; i++) begin
        x_q[i]   <= '0;
        res_q[i] <= '0;
      end
      for (int r = 0; r < D; r++)
        for (int j = 0; j <= D; j++)
          coef_q[coef_index(r, j, D)] <= (j == r) ? COEF_ONE : '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      x_q     <= x_d;
      res_q   <= res_d;
      coef_q  <= coef_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < D; i++) out_data[i*N +: N] = res_q[i];
    out_sat = sat_q;
  end

endmodule

// File: tb/tb_affine_mac_engine.sv
// Directed bench for affine_mac_engine (N=8, F=6, D=2): stimulus pushes hand
// computed results into a scoreboard; a monitor pops on each output handshake.
module tb_affine_mac_engine;

  localparam int N  = 8;
  localparam int D  = 2;
  localparam int CA = $clog2(D*(D+1));
`ifdef AFFINE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            coef_we;
  logic [CA-1:0]   coef_addr;
  logic [N-1:0]    coef_wdata;
  logic            coef_ready;
  logic            in_valid;
  logic            in_ready;
  logic [D*N-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [D*N-1:0]  out_data;
  logic [D-1:0]    out_sat;

  affine_mac_engine dut (
    .clk        (clk),
    .reset      (reset),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_ready (coef_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int y0, input int y1, input logic [1:0] s);
    exp_t e;
    e.data = {y1[7:0], y0[7:0]};
    e.sat  = s;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("result_data", {16'd0, out_data}, {16'd0, mon_e.data});
        chk("result_sat", {30'd0, out_sat}, {30'd0, mon_e.sat});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = CA'(addr);
    coef_wdata = N'(val);
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (coef_ready && !out_valid && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy expected idle");
    end
    tick();
  endtask

  task automatic send(input int a, input int b, input exp_t e, input bit track);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = {b[7:0], a[7:0]};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (track) sb.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_accept: got in_ready=0 expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_sat", {30'd0, out_sat}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_coef_ready", {31'd0, coef_ready}, 32'd1);
    tick();

    // identity pass-through and accept-to-valid latency
    send(5, -3, mk(5, -3, 2'b00), 1'b1);
    wait_valid(n);
    chk("latency", n - 1, 32'd4);
    wait_idle();

    wr(0, 32); wr(1, 0); wr(2, 10); wr(3, 0); wr(4, -64); wr(5, 0);
    send(20, 7, mk(20, -7, 2'b00), 1'b1);
    wait_idle();

    wr(2, 0);
    send(-3, 5, mk(-2, -5, 2'b00), 1'b1);
    wait_idle();

    wr(0, 127);
    send(100, 0, mk(SAT ? 127 : -58, 0, SAT ? 2'b01 : 2'b00), 1'b1);
    wait_idle();
    send(-100, 0, mk(SAT ? -128 : 57, 0, SAT ? 2'b01 : 2'b00), 1'b1);
    wait_idle();

    wr(0, 64); wr(1, 64); wr(2, -5); wr(3, -32); wr(4, 16); wr(5, 3);
    send(10, -20, mk(-15, -7, 2'b00), 1'b1);
    wait_idle();

    wr(1, 0); wr(2, 0);
    send(127, 0, mk(127, -61, 2'b00), 1'b1);
    wait_idle();
    wr(2, 1);
    send(127, 0, mk(SAT ? 127 : -128, -61, SAT ? 2'b01 : 2'b00), 1'b1);
    wait_idle();

    // write and accept in the same IDLE cycle: new M00 applies
    coef_we    = 1'b1;
    coef_addr  = CA'(0);
    coef_wdata = N'(32);
    in_valid   = 1'b1;
    in_data    = {8'd0, 8'd4};
    @(negedge clk);
    chk("same_cycle_coef_ready", {31'd0, coef_ready}, 32'd1);
    chk("same_cycle_in_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back(mk(3, 1, 2'b00));
    tick();
    coef_we  = 1'b0;
    in_valid = 1'b0;
    wait_idle();

    // backpressure: result held, input blocked, coefficient write dropped
    out_ready = 1'b0;
    send(8, 0, mk(5, -1, 2'b00), 1'b1);
    wait_valid(n);
    chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      coef_we    = 1'b1;
      coef_addr  = CA'(0);
      coef_wdata = N'(0);
      in_valid   = 1'b1;
      in_data    = {8'd6, 8'd2};
      @(negedge clk);
      chk("bp_out_data", {16'd0, out_data}, 32'h0000FF05);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_coef_ready", {31'd0, coef_ready}, 32'd0);
    end
    tick();
    coef_we   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back(mk(2, 3, 2'b00));
    tick();
    in_valid = 1'b0;
    wait_idle();

    // reset in MAC cycle 2 aborts and restores identity
    send(1, 1, mk(0, 0, 2'b00), 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("abort_coef_ready", {31'd0, coef_ready}, 32'd1);
    tick();
    send(9, 9, mk(9, 9, 2'b00), 1'b1);
    wait_idle();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
